// File: rtl/pipe_rx_lane_packer.sv
// pipe_rx_lane_packer: per-lane packing of variable-width PIPE Rx beats into 32-bit words with 128b/130b block tracking
module pipe_rx_lane_packer #(
  parameter int LANES  = 4,
  parameter int GEN1_W = 8,
  parameter int GEN2_W = 16,
  parameter int GEN3_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           GEN,
  input  logic [LANES-1:0]     RxValid,
  input  logic [LANES-1:0]     RxStartBlock,
  input  logic [3*LANES-1:0]   RxStatus,
  input  logic [2*LANES-1:0]   RxSyncHeader,
  input  logic [LANES-1:0]     RxElectricalIdle,
  input  logic [32*LANES-1:0]  RxData,
  input  logic [4*LANES-1:0]   RxDataK,
  output logic [LANES-1:0]     out_valid,
  output logic [32*LANES-1:0]  out_data,
  output logic [4*LANES-1:0]   out_datak,
  output logic [LANES-1:0]     out_sob,
  output logic [2*LANES-1:0]   out_sync_hdr,
  output logic [LANES-1:0]     out_eidle,
  output logic [LANES-1:0]     err_status,
  output logic [LANES-1:0]     err_block
);
  localparam logic [2:0] NB1 = 3'(GEN1_W / 8);
  localparam logic [2:0] NB2 = 3'(GEN2_W / 8);
  localparam logic [2:0] NB3 = 3'(GEN3_W / 8);
  logic [2:0] gen_q;
  logic       chg, gen_ok, g3;
  logic [2:0] nb;
  logic [3:0] bm_w;
  assign chg    = GEN != gen_q;
  assign gen_ok = GEN != 3'd0 && GEN <= 3'd5;
  assign g3     = GEN >= 3'd3 && GEN <= 3'd5;
  assign nb     = GEN == 3'd1 ? NB1 : GEN == 3'd2 ? NB2 : NB3;
  assign bm_w   = nb == 3'd4 ? 4'hf : nb == 3'd2 ? 4'h3 : 4'h1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) gen_q <= '0;
    else gen_q <= GEN;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0] acc_q, acc_d, dat_q, dat_d, d_in, bmx;
    logic [3:0]  acck_q, acck_d, datk_q, datk_d, blk_q, blk_d, k_in, bm;
    logic [1:0]  off_q, off_d, hdr_q, hdr_d, shdr_q, shdr_d;
    logic [2:0]  sum;
    logic        sobp_q, sobp_d, vld_q, vld_d, sob_q, sob_d, eid_q;
    logic        ests_q, ests_d, eblk_q, eblk_d;
    assign d_in = RxData[32*l +: 32];
    assign k_in = RxDataK[4*l +: 4];
    always_comb begin
      acc_d  = acc_q;
      acck_d = acck_q;
      off_d  = off_q;
      blk_d  = blk_q;
      hdr_d  = hdr_q;
      sobp_d = sobp_q;
      dat_d  = dat_q;
      datk_d = datk_q;
      vld_d  = 1'b0;
      sob_d  = 1'b0;
      shdr_d = '0;
      ests_d = 1'b0;
      eblk_d = 1'b0;
      bm     = '0;
      bmx    = '0;
      sum    = '0;
      if (RxElectricalIdle[l] || chg) begin
        acc_d  = '0;
        acck_d = '0;
        off_d  = '0;
        blk_d  = '0;
        sobp_d = 1'b0;
      end
      if (!RxElectricalIdle[l] && gen_ok && RxValid[l]) begin
        if (RxStatus[3*l +: 3] != 3'd0) begin
          ests_d = 1'b1;
          acc_d  = '0;
          acck_d = '0;
          off_d  = '0;
          blk_d  = '0;
          sobp_d = 1'b0;
        end else if (g3 && blk_d == 4'd0 && !RxStartBlock[l]) begin
          eblk_d = 1'b1;
        end else begin
          // A start beat always opens a fresh block; mid-block it is also an alignment error
          if (g3 && RxStartBlock[l]) begin
            eblk_d = blk_d != 4'd0;
            acc_d  = '0;
            acck_d = '0;
            off_d  = '0;
            blk_d  = '0;
            sobp_d = 1'b1;
            hdr_d  = RxSyncHeader[2*l +: 2];
          end
          bm     = bm_w << off_d;
          bmx    = {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
          acc_d  = (acc_d & ~bmx) | ((d_in << {off_d, 3'b000}) & bmx);
          acck_d = (acck_d & ~bm) | ((k_in << off_d) & bm);
          sum    = {1'b0, off_d} + nb;
          off_d  = sum[1:0];
          blk_d  = g3 ? blk_d + {1'b0, nb} : '0;
          if (sum[2]) begin
            vld_d  = 1'b1;
            dat_d  = acc_d;
            datk_d = g3 ? '0 : acck_d;
            sob_d  = g3 && sobp_d;
            shdr_d = sob_d ? hdr_d : '0;
            sobp_d = 1'b0;
            acc_d  = '0;
            acck_d = '0;
          end
        end
      end
    end
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        acc_q  <= '0;
        acck_q <= '0;
        off_q  <= '0;
        blk_q  <= '0;
        hdr_q  <= '0;
        sobp_q <= 1'b0;
        dat_q  <= '0;
        datk_q <= '0;
        vld_q  <= 1'b0;
        sob_q  <= 1'b0;
        shdr_q <= '0;
        eid_q  <= 1'b0;
        ests_q <= 1'b0;
        eblk_q <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        acck_q <= acck_d;
        off_q  <= off_d;
        blk_q  <= blk_d;
        hdr_q  <= hdr_d;
        sobp_q <= sobp_d;
        dat_q  <= dat_d;
        datk_q <= datk_d;
        vld_q  <= vld_d;
        sob_q  <= sob_d;
        shdr_q <= shdr_d;
        eid_q  <= RxElectricalIdle[l];
        ests_q <= ests_d;
        eblk_q <= eblk_d;
      end
    assign out_valid[l]          = vld_q;
    assign out_data[32*l +: 32]  = dat_q;
    assign out_datak[4*l +: 4]   = datk_q;
    assign out_sob[l]            = sob_q;
    assign out_sync_hdr[2*l +: 2] = shdr_q;
    assign out_eidle[l]          = eid_q;
    assign err_status[l]         = ests_q;
    assign err_block[l]          = eblk_q;
  end
endmodule

// File: tb/tb_pipe_rx_lane_packer.sv
// tb_pipe_rx_lane_packer: directed-vector bench for the multi-lane PIPE Rx packer
module tb_pipe_rx_lane_packer;
  logic         clk = 1'b0, reset = 1'b0;
  logic [2:0]   GEN;
  logic [3:0]   RxValid, RxStartBlock, RxElectricalIdle, out_valid, out_sob, out_eidle, err_status, err_block;
  logic [11:0]  RxStatus;
  logic [7:0]   RxSyncHeader, out_sync_hdr;
  logic [127:0] RxData, out_data;
  logic [15:0]  RxDataK, out_datak;
  logic [2:0]   g8, st8;
  logic         v8, sb8, ei8, o_v8, o_sob8, o_ei8, o_es8, o_eb8;
  logic [1:0]   sh8, o_hdr8;
  logic [31:0]  d8, o_d8;
  logic [3:0]   k8, o_k8;
  int checks = 0, errors = 0;

  pipe_rx_lane_packer dut (
    .clk(clk), .reset(reset), .GEN(GEN), .RxValid(RxValid), .RxStartBlock(RxStartBlock),
    .RxStatus(RxStatus), .RxSyncHeader(RxSyncHeader), .RxElectricalIdle(RxElectricalIdle),
    .RxData(RxData), .RxDataK(RxDataK), .out_valid(out_valid), .out_data(out_data),
    .out_datak(out_datak), .out_sob(out_sob), .out_sync_hdr(out_sync_hdr), .out_eidle(out_eidle),
    .err_status(err_status), .err_block(err_block)
  );

  pipe_rx_lane_packer #(.LANES(1), .GEN3_W(8)) dut8 (
    .clk(clk), .reset(reset), .GEN(g8), .RxValid(v8), .RxStartBlock(sb8),
    .RxStatus(st8), .RxSyncHeader(sh8), .RxElectricalIdle(ei8),
    .RxData(d8), .RxDataK(k8), .out_valid(o_v8), .out_data(o_d8),
    .out_datak(o_k8), .out_sob(o_sob8), .out_sync_hdr(o_hdr8), .out_eidle(o_ei8),
    .err_status(o_es8), .err_block(o_eb8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    RxValid = '0; RxStartBlock = '0; RxStatus = '0; RxSyncHeader = '0;
    RxElectricalIdle = '0; RxData = '0; RxDataK = '0;
  endtask

  task automatic drv(input int l, input logic [31:0] d, input logic [3:0] k, input logic sb, input logic [1:0] h);
    RxValid[l] = 1'b1;
    RxData[32*l +: 32] = d;
    RxDataK[4*l +: 4] = k;
    RxStartBlock[l] = sb;
    RxSyncHeader[2*l +: 2] = h;
  endtask

  task automatic b8(input logic [7:0] d, input logic sb, input logic [1:0] h);
    v8 = 1'b1; d8 = {24'hFFFFFF, d}; sb8 = sb; sh8 = h;
    tick();
  endtask

  initial begin
    clr_in();
    GEN = 3'd1;
    g8 = 3'd3; v8 = 0; sb8 = 0; st8 = 0; sh8 = 0; ei8 = 0; d8 = 0; k8 = 0;
    // activity during reset must not reach the outputs
    RxElectricalIdle = 4'hF; RxValid = 4'hF; RxData = {4{32'h12345678}};
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_eidle", out_eidle, 0);
    check("rst_errs", {err_status, err_block, out_sob, out_sync_hdr}, 0);
    clr_in();
    reset = 1'b1;
    tick();

    // GEN1 byte packing with a gap
    drv(0, 32'hFFFFFF11, 4'hF, 0, 0); tick();
    check("g1_b1_novalid", out_valid, 0);
    clr_in(); drv(0, 32'h22, 0, 0, 0); tick();
    clr_in(); tick();
    drv(0, 32'h33, 0, 0, 0); tick();
    check("g1_b3_novalid", out_valid, 0);
    clr_in(); drv(0, 32'h44, 0, 0, 0); tick();
    check("g1_valid", out_valid, 4'b0001);
    check("g1_data", out_data[31:0], 32'h44332211);
    check("g1_datak", out_datak[3:0], 4'b0001);
    check("g1_sob", out_sob, 0);
    clr_in(); tick();
    check("g1_pulse", out_valid, 0);
    check("g1_hold", out_data[31:0], 32'h44332211);

    // GEN3 W=32 block on lane 1
    GEN = 3'd3; tick();
    drv(1, 32'hA0A1A2A3, 4'hF, 1, 2'b01); tick();
    check("g3_w0_valid", out_valid, 4'b0010);
    check("g3_w0_data", out_data[63:32], 32'hA0A1A2A3);
    check("g3_w0_datak", out_datak[7:4], 0);
    check("g3_w0_sob", out_sob, 4'b0010);
    check("g3_w0_hdr", out_sync_hdr, 8'b00000100);
    clr_in(); drv(1, 32'hB0B1B2B3, 0, 0, 2'b11); tick();
    check("g3_w1_valid", out_valid, 4'b0010);
    check("g3_w1_sob", {out_sob, out_sync_hdr}, 0);
    check("g3_w1_data", out_data[63:32], 32'hB0B1B2B3);
    clr_in(); drv(1, 32'hC0C1C2C3, 0, 0, 0); tick();
    check("g3_w2_valid", out_valid, 4'b0010);
    clr_in(); drv(1, 32'hD0D1D2D3, 0, 0, 0); tick();
    check("g3_w3_valid", out_valid, 4'b0010);
    check("g3_w3_sob", out_sob, 0);
    clr_in(); drv(1, 32'hE0E1E2E3, 0, 0, 0); tick();
    check("g3_nostart_valid", out_valid, 0);
    check("g3_nostart_eblk", err_block, 4'b0010);
    check("g3_nostart_hold", out_data[63:32], 32'hD0D1D2D3);
    clr_in(); tick();
    check("g3_eblk_pulse", err_block, 0);

    // GEN3 with 8-bit width: restart after 6 bytes
    b8(8'h10, 1, 2'b01); b8(8'h11, 0, 0); b8(8'h12, 0, 0); b8(8'h13, 0, 0);
    check("w8_first_valid", o_v8, 1);
    check("w8_first_data", o_d8, 32'h13121110);
    check("w8_first_sob", {o_sob8, o_hdr8}, 3'b101);
    b8(8'h14, 0, 0);
    check("w8_mid_sob", o_sob8, 0);
    b8(8'h15, 0, 0);
    b8(8'h20, 1, 2'b10);
    check("w8_restart_eblk", o_eb8, 1);
    check("w8_restart_novalid", o_v8, 0);
    b8(8'h21, 0, 0); b8(8'h22, 0, 0);
    check("w8_partial_gone", o_v8, 0);
    b8(8'h23, 0, 0);
    check("w8_new_valid", o_v8, 1);
    check("w8_new_data", o_d8, 32'h23222120);
    check("w8_new_sob", {o_sob8, o_hdr8}, 3'b110);
    check("w8_new_datak", o_k8, 0);
    v8 = 0;

    // GEN2 RxStatus error mid-word on lane 2
    GEN = 3'd2; tick();
    drv(2, 32'hBBAA, 0, 0, 0); tick();
    check("g2_half_novalid", out_valid, 0);
    clr_in(); drv(2, 32'h1234, 0, 0, 0); RxStatus[8:6] = 3'b100; tick();
    check("g2_estat", err_status, 4'b0100);
    check("g2_estat_novalid", out_valid, 0);
    clr_in(); drv(2, 32'hDDCC, 0, 0, 0); tick();
    check("g2_estat_pulse", err_status, 0);
    check("g2_discard", out_valid, 0);
    clr_in(); drv(2, 32'hFFEE, 0, 0, 0); tick();
    check("g2_valid", out_valid, 4'b0100);
    check("g2_data", out_data[95:64], 32'hFFEEDDCC);

    // GEN1 partial, electrical idle, then GEN5 start
    clr_in(); GEN = 3'd1; tick();
    drv(3, 32'h01, 0, 0, 0); tick(); tick(); tick();
    clr_in(); RxElectricalIdle[3] = 1'b1; tick();
    check("ei_c1", out_eidle, 4'b1000);
    check("ei_c1_novalid", out_valid, 0);
    tick();
    check("ei_c2", out_eidle, 4'b1000);
    clr_in(); GEN = 3'd5; tick();
    check("ei_off", out_eidle, 0);
    check("ei_novalid", out_valid, 0);
    check("ei_noerr", {err_status, err_block}, 0);
    drv(3, 32'h0D0C0B0A, 4'hF, 1, 2'b10); tick();
    check("g5_valid", out_valid, 4'b1000);
    check("g5_sob", out_sob, 4'b1000);
    check("g5_hdr", out_sync_hdr, 8'b10000000);
    check("g5_data", out_data[127:96], 32'h0D0C0B0A);

    // all lanes in parallel, then asynchronous reset mid-block
    clr_in(); GEN = 3'd3; tick();
    for (int l = 0; l < 4; l++) drv(l, 32'h5A5A0000 + l, 0, 1, 2'(l));
    tick();
    check("ml_valid", out_valid, 4'hF);
    check("ml_data", out_data, {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000});
    check("ml_sob", out_sob, 4'hF);
    check("ml_hdr", out_sync_hdr, 8'b11100100);
    clr_in(); drv(0, 32'h11110000, 0, 0, 0); drv(2, 32'h22220000, 0, 0, 0); tick();
    check("ml2_valid", out_valid, 4'b0101);
    check("ml2_data", out_data, {32'h5A5A0003, 32'h22220000, 32'h5A5A0001, 32'h11110000});
    check("ml2_sob", {out_sob, out_sync_hdr}, 0);
    clr_in(); drv(0, 32'h33330000, 0, 0, 0); tick();
    #1 reset = 1'b0;
    #1;
    check("arst_data", out_data, 0);
    check("arst_flags", {out_valid, out_sob, out_sync_hdr, out_datak[3:0], err_status, err_block}, 0);
    clr_in(); tick();
    reset = 1'b1;
    tick();
    drv(1, 32'h77777777, 0, 1, 2'b11); drv(0, 32'h66, 0, 0, 0); tick();
    check("rs_valid", out_valid, 4'b0010);
    check("rs_sob", out_sob, 4'b0010);
    check("rs_hdr", out_sync_hdr, 8'b00001100);
    check("rs_eblk", err_block, 4'b0001);
    check("rs_data", out_data, {64'h0, 32'h77777777, 32'h0});
    clr_in(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_rx_lane_packer.md
Name: pipe_rx_lane_packer

Overview:
- Multi-lane successor to the single-lane PIPE Rx data stage.
- Per lane, takes variable-width PIPE Rx beats (8/16/32 bits selected by GEN) and packs them little-endian into fixed 32-bit MAC-side words with DataK.
- For 128b/130b generations (GEN>=3) it also tracks 16-byte block boundaries, attaching the sync header and a start-of-block flag.
- Invalid beats, RxStatus errors and block misalignment are filtered and flagged.

Parameters:
- LANES, 4, number of independent lanes (1..16).
- GEN1_W, 8, PIPE data width in bits at GEN 1 (8/16/32).
- GEN2_W, 16, PIPE data width in bits at GEN 2 (8/16/32).
- GEN3_W, 32, PIPE data width in bits at GEN 3, 4 and 5 (8/16/32).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- GEN  in  3  current generation, shared by all lanes; valid values 1..5.
- RxValid  in  LANES  per-lane beat valid.
- RxStartBlock  in  LANES  per-lane first beat of a 128b/130b block.
- RxStatus  in  3*LANES  per-lane PIPE status; 0 = OK.
- RxSyncHeader  in  2*LANES  per-lane sync header, meaningful with RxStartBlock.
- RxElectricalIdle  in  LANES  per-lane electrical idle.
- RxData  in  32*LANES  per-lane data; lane n uses [32n+W-1:32n].
- RxDataK  in  4*LANES  per-lane K flags; lane n uses [4n+W/8-1:4n].
- out_valid  out  LANES  packed word valid (1-cycle pulse per word).
- out_data  out  32*LANES  packed word; first received byte in [7:0].
- out_datak  out  4*LANES  K flag per byte of out_data.
- out_sob  out  LANES  word is the first word of a block (GEN>=3 only).
- out_sync_hdr  out  2*LANES  sync header of the block; valid with out_sob, else 0.
- out_eidle  out  LANES  registered RxElectricalIdle.
- err_status  out  LANES  1-cycle pulse: beat dropped due to RxStatus!=0.
- err_block  out  LANES  1-cycle pulse: block alignment violation.

Behaviour:
- Reset: all outputs 0, accumulators empty, byte counters 0, block counters 0.
- Width selection: W = GEN1_W for GEN 1; GEN2_W for GEN 2; GEN3_W for GEN 3..5. For GEN 0, 6 and 7, all beats are ignored and no errors are raised.
- Accepted beat: RxValid=1, RxStatus=0, RxElectricalIdle=0, plus the alignment rule below.
- Accumulation:
  - Each accepted beat appends W/8 bytes (and DataK bits) at the current byte offset.
  - The byte offset advances mod 4.
  - When the offset reaches 4, the word is output registered: out_valid is high in the cycle after the completing beat.
  - Latency: 1 cycle from the completing beat to out_valid.
  - out_data/out_datak hold their value between pulses.
- Beats with RxValid=0 are skipped; the accumulator is held and there is no gap limit.
- RxStatus!=0 with RxValid=1:
  - The beat is dropped and the partial word is discarded.
  - err_status pulses next cycle.
  - The block counter resets to 0.
- RxElectricalIdle=1: the partial word is discarded, counters are cleared, nothing is accepted, and no error is raised. out_eidle follows with 1-cycle delay.
- GEN change (GEN differs from its registered previous value): partial word and counters are cleared in that cycle. The beat present in that cycle is processed with the new W, from offset 0.
- GEN 1/2 (8b/10b): the block logic is inactive; out_sob=0 and out_sync_hdr=0.
- GEN>=3 block tracking uses a block byte counter 0..15:
  - Expected start (counter=0): the beat must carry RxStartBlock=1. It is accepted; RxSyncHeader is latched and the pending word is marked sob.
  - If the counter is 0 and RxStartBlock=0: the beat is dropped and err_block pulses.
  - If the counter is not 0 and RxStartBlock=1: err_block pulses, the partial word is discarded, and the beat starts a new block (header latched, counter restarts).
  - The counter advances by W/8 per accepted beat and wraps 15 -> 0 at block end.
- out_sob and out_sync_hdr are asserted only with the out_valid of the first word of a block, otherwise 0. DataK bits are forced to 0 for GEN>=3.
- Simultaneous events, priority per lane: electrical idle > GEN change > RxStatus error > alignment error > normal accept.
- Lanes are fully independent except for the shared GEN.
- Reset asserted mid-word or mid-block: immediate return to reset state; no output for the partial data.

Test Plan:
- GEN=1, lane0 beats 0x11, 0x22, 0x33, 0x44 (K on 0x11), one RxValid=0 gap -> single out_valid; out_data=0x44332211, out_datak=4'b0001, out_sob=0.
- GEN=3, W=32, lane1: RxStartBlock=1 with hdr=2'b01 and data 0xA0A1A2A3, then 3 more beats -> 4 out_valid pulses; only the first has out_sob=1 and out_sync_hdr=01. A 5th beat without RxStartBlock -> dropped, err_block pulse.
- GEN=3, GEN3_W=8: RxStartBlock again after 6 bytes -> err_block pulse; 2-byte partial word discarded; new block's first word has out_sob=1.
- GEN=2 mid-word: 16-bit beat 0xBBAA, then RxStatus=3'b100 on the next beat -> err_status pulse, no output. The following two beats 0xDDCC, 0xFFEE -> out_data=0xFFEEDDCC.
- GEN=1, 3 bytes accumulated, then RxElectricalIdle=1 for 2 cycles; then GEN changes to 5 -> no output, out_eidle high for 2 cycles delayed by 1. The next GEN 5 start beat yields a word with out_sob=1.
- LANES=4, different traffic per lane plus reset asserted mid-block -> outputs 0 immediately, no cross-lane corruption before reset, clean restart after reset.
